// File: rtl/cla_serial_addsub_sequencer_if.sv
// Operand/result handshake bundle for the serial CLA add/sub sequencer.
// The producer/consumer side uses master; the sequencer uses slave.
interface cla_serial_addsub_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, op_sub, op_a, op_b, carry_in, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero, busy
  );

  modport slave (
    input  in_valid, op_sub, op_a, op_b, carry_in, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero, busy
  );
endinterface

// File: rtl/cla_serial_addsub_sequencer.sv
// Wide add/subtract built from one 4-bit carry-lookahead slice, reused
// once per nibble (LSB first) with the nibble carry held in a register.
module cla_serial_addsub_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  cla_serial_addsub_sequencer_if.slave bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q, result_q, res_nx;
  logic             sub_q, carry_q;
  logic [IDX_W-1:0] idx;
  logic             carry_out_q, ovf_q, zero_q;
  logic [5:0]       slice;
  logic             accept;

  // 4-bit lookahead slice: returns {carry out of bit 3, carry into bit 3, sum}.
  function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic c0);
    logic [3:0] g, p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], c[3], p ^ c[3:0]};
  endfunction

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (idx == LAST_IDX) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Subtract inverts B here; the +1 arrives through the preloaded carry.
  always_comb begin
    slice  = cla4(a_q[idx*4 +: 4], b_q[idx*4 +: 4] ^ {4{sub_q}}, carry_q);
    res_nx = result_q;
    res_nx[idx*4 +: 4] = slice[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      idx         <= '0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q     <= bus.op_a;
          b_q     <= bus.op_b;
          sub_q   <= bus.op_sub;
          carry_q <= bus.op_sub ? 1'b1 : bus.carry_in;
          idx     <= '0;
        end
        RUN: begin
          result_q <= res_nx;
          carry_q  <= slice[5];
          // Index parks at the last nibble; it is reloaded on the next accept.
          if (idx == LAST_IDX) begin
            carry_out_q <= slice[5];
            ovf_q       <= slice[5] ^ slice[4];
            zero_q      <= (res_nx == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_serial_addsub_sequencer.sv
// Directed bench for the serial CLA add/sub sequencer at WIDTH = 16.
module tb_cla_serial_addsub_sequencer;
  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cla_serial_addsub_sequencer_if #(.WIDTH(WIDTH)) ifc ();

  cla_serial_addsub_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_op(input logic sub, input logic [15:0] a, input logic [15:0] b,
                         input logic cin);
    ifc.op_sub   = sub;
    ifc.op_a     = a;
    ifc.op_b     = b;
    ifc.carry_in = cin;
  endtask

  // Issue one operation, measure latency, check result/flags, then drain it.
  task automatic run_op(input string tag, input logic sub, input logic [15:0] a,
                        input logic [15:0] b, input logic cin, input logic [15:0] exp_r,
                        input logic exp_c, input logic exp_v, input logic exp_z);
    int lat;
    load_op(sub, a, b, cin);
    ifc.in_valid = 1'b1;
    check_eq({tag, "_in_ready"}, 32'(ifc.in_ready), 32'd1);
    tick();
    ifc.in_valid = 1'b0;
    lat = 0;
    while (!ifc.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(NIBBLES));
    check_eq({tag, "_result"},  32'(ifc.result),    32'(exp_r));
    check_eq({tag, "_carry"},   32'(ifc.carry_out), 32'(exp_c));
    check_eq({tag, "_ovf"},     32'(ifc.overflow),  32'(exp_v));
    check_eq({tag, "_zero"},    32'(ifc.zero),      32'(exp_z));
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    check_eq({tag, "_drained"}, 32'({ifc.out_valid, ifc.in_ready}), 32'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bb_a   [3];
    logic [15:0] bb_b   [3];
    logic        bb_sub [3];
    logic        bb_cin [3];
    logic [15:0] bb_exp [3];
    int acc_cyc [3];
    int nacc, nres;
    logic accepting;

    rst = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    load_op(1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    tick();
    check_eq("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    check_eq("rst_outs", 32'({ifc.out_valid, ifc.busy, ifc.carry_out, ifc.overflow, ifc.zero}), 32'd0);
    check_eq("rst_result", 32'(ifc.result), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 32'(ifc.in_ready), 32'd1);

    // Basic add / subtract / boundary vectors.
    run_op("add_basic",  1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
    run_op("sub_cin1",   1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_cin0",   1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("add_ovf",    1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("add_wrap",   1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("add_cin",    1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    run_op("sub_ovf",    1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("sub_equal",  1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Backpressure in DONE with a competing request.
    load_op(1'b0, 16'h1111, 16'h2222, 1'b0);
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    for (int k = 0; k < NIBBLES; k++) tick();
    check_eq("bp_enter_done", 32'(ifc.out_valid), 32'd1);
    load_op(1'b1, 16'hAAAA, 16'h5555, 1'b0);
    ifc.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("bp_hold", 32'({ifc.out_valid, ifc.in_ready, ifc.result}), {15'd0, 1'b1, 1'b0, 16'h3333});
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    check_eq("bp_release", 32'({ifc.out_valid, ifc.busy, ifc.in_ready}), 32'b001);
    check_eq("bp_result_held", 32'(ifc.result), 32'h3333);

    // Reset while RUN is on nibble 2.
    load_op(1'b0, 16'hFFFF, 16'h8001, 1'b0);
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    tick();
    tick();
    check_eq("mid_busy", 32'({ifc.busy, ifc.out_valid}), 32'b10);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_in_ready", 32'(ifc.in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_outs", 32'({ifc.out_valid, ifc.busy, ifc.carry_out, ifc.overflow, ifc.zero}), 32'd0);
    check_eq("mid_rst_result", 32'(ifc.result), 32'd0);
    run_op("post_rst_add", 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    // Back-to-back issue with in_valid and out_ready held high.
    bb_sub[0] = 1'b0; bb_a[0] = 16'hA5A5; bb_b[0] = 16'h5A5A; bb_cin[0] = 1'b0; bb_exp[0] = 16'hFFFF;
    bb_sub[1] = 1'b1; bb_a[1] = 16'h0010; bb_b[1] = 16'h0001; bb_cin[1] = 1'b1; bb_exp[1] = 16'h000F;
    bb_sub[2] = 1'b0; bb_a[2] = 16'hFFFF; bb_b[2] = 16'h0000; bb_cin[2] = 1'b1; bb_exp[2] = 16'h0000;
    nacc = 0;
    nres = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
    load_op(bb_sub[0], bb_a[0], bb_b[0], bb_cin[0]);
    ifc.in_valid  = 1'b1;
    ifc.out_ready = 1'b1;
    for (int c = 0; c < 60 && nres < 3; c++) begin
      if (ifc.out_valid) begin
        check_eq("b2b_result", 32'(ifc.result), 32'(bb_exp[nres]));
        nres++;
      end
      accepting = ifc.in_ready && (nacc < 3);
      if (accepting) acc_cyc[nacc] = c;
      tick();
      if (accepting) begin
        nacc++;
        if (nacc < 3) load_op(bb_sub[nacc], bb_a[nacc], bb_b[nacc], bb_cin[nacc]);
        else          ifc.in_valid = 1'b0;
      end
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    check_eq("b2b_count", 32'(nres), 32'd3);
    check_eq("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(NIBBLES + 2));
    check_eq("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(NIBBLES + 2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
